// File: rtl/csa_result_fifo.sv
// Four-entry result FIFO for carry-save adder outputs: stores {cout, sum}, tracks overflow and carry count.
// Optional carry counter is enabled by defining CSA_RESULT_CARRY_CNT_EN; otherwise carry_cnt is tied to zero.
module csa_result_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_sum,
  input  logic       in_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_data,
  output logic [2:0] level,
  output logic       ovf,
  output logic [7:0] carry_cnt
);

  logic [8:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] level_q, level_d;
  logic       ovf_q, ovf_d;
  logic       push, pop;

  assign in_ready  = (level_q != 3'd4);
  assign out_valid = (level_q != 3'd0);
  assign push      = in_valid && in_ready && !clr;
  assign pop       = out_valid && out_ready && !clr;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 9'h000;
  assign level     = level_q;
  assign ovf       = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      level_d  = 3'd0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   level_d = level_q + 3'd1;
        2'b01:   level_d = level_q - 3'd1;
        default: level_d = level_q;
      endcase
      if (in_valid && !in_ready) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      level_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset; out_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_cout, in_sum};
  end

`ifdef CSA_RESULT_CARRY_CNT_EN
  logic [7:0] carry_cnt_q, carry_cnt_d;

  always_comb begin
    carry_cnt_d = carry_cnt_q;
    if (clr)
      carry_cnt_d = 8'h00;
    else if (push && in_cout && (carry_cnt_q != 8'hFF))
      carry_cnt_d = carry_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_cnt_q <= 8'h00;
    else        carry_cnt_q <= carry_cnt_d;
  end

  assign carry_cnt = carry_cnt_q;
`else
  assign carry_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_csa_result_fifo.sv
// Directed bench for csa_result_fifo with a queue-based scoreboard and reference model.
module tb_csa_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_sum = 8'h00;
  logic       in_cout = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_data;
  logic [2:0] level;
  logic       ovf;
  logic [7:0] carry_cnt;

  int         n_checks = 0;
  int         n_err = 0;
  logic [8:0] sb_q[$];
  logic       ovf_m = 1'b0;
  logic [7:0] carry_m = 8'h00;

  csa_result_fifo dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .ovf(ovf), .carry_cnt(carry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [8:0] head;
    head = (sb_q.size() != 0) ? sb_q[0] : 9'h000;
    chk({tag, ".level"},     {29'd0, level},          sb_q.size());
    chk({tag, ".in_ready"},  {31'd0, in_ready},       {31'd0, sb_q.size() != 4});
    chk({tag, ".out_valid"}, {31'd0, out_valid},      {31'd0, sb_q.size() != 0});
    chk({tag, ".out_data"},  {23'd0, out_data},       {23'd0, head});
    chk({tag, ".ovf"},       {31'd0, ovf},            {31'd0, ovf_m});
    chk({tag, ".carry_cnt"}, {24'd0, carry_cnt},      {24'd0, carry_m});
  endtask

  // Drive one cycle of stimulus, check current outputs, advance the model, then clock.
  task automatic cycle(input string tag, input logic v, input logic [8:0] d,
                       input logic rdy, input logic c);
    logic do_push, do_pop;
    in_valid = v; in_cout = d[8]; in_sum = d[7:0]; out_ready = rdy; clr = c;
    #1;
    chk_state(tag);
    if (c) begin
      sb_q.delete();
      ovf_m = 1'b0;
      carry_m = 8'h00;
    end else begin
      do_push = v && (sb_q.size() != 4);
      do_pop  = rdy && (sb_q.size() != 0);
      if (v && sb_q.size() == 4) ovf_m = 1'b1;
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) begin
        sb_q.push_back(d);
`ifdef CSA_RESULT_CARRY_CNT_EN
        if (d[8] && carry_m != 8'hFF) carry_m = carry_m + 8'd1;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] pat [4];
    pat[0] = 9'h101; pat[1] = 9'h0FF; pat[2] = 9'h100; pat[3] = 9'h00A;

    #3;
    chk_state("reset_hold");
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    cycle("push_5a", 1'b1, 9'h05A, 1'b0, 1'b0);
    chk("after_push.out_data", {23'd0, out_data}, 32'h05A);
    chk("after_push.level", {29'd0, level}, 32'd1);
    cycle("pop_5a", 1'b0, 9'h000, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, pat[i], 1'b0, 1'b0);
    cycle("full_idle", 1'b0, 9'h000, 1'b0, 1'b0);
    cycle("full_offer", 1'b1, 9'h1EE, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("full_level", {29'd0, level}, 32'd4);
    for (int i = 0; i < 4; i++) cycle("drain_order", 1'b0, 9'h000, 1'b1, 1'b0);
    cycle("empty_idle", 1'b0, 9'h000, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) cycle("refill", 1'b1, 9'h180 + 9'(i), 1'b0, 1'b0);
    cycle("clr_push_pop", 1'b1, 9'h133, 1'b1, 1'b1);
    chk("clr_level", {29'd0, level}, 32'd0);
    chk("clr_ovf", {31'd0, ovf}, 32'd0);
    chk("clr_carry", {24'd0, carry_cnt}, 32'd0);

    cycle("lvl2_a", 1'b1, 9'h010, 1'b0, 1'b0);
    cycle("lvl2_b", 1'b1, 9'h011, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle("push_pop_wrap", 1'b1, 9'h012 + 9'(i), 1'b1, 1'b0);
    chk("wrap_level", {29'd0, level}, 32'd2);
    cycle("wrap_drain0", 1'b0, 9'h000, 1'b1, 1'b0);
    cycle("wrap_drain1", 1'b0, 9'h000, 1'b1, 1'b0);

    for (int i = 0; i < 260; i++) cycle("stream_cout", 1'b1, {1'b1, 8'(i)}, 1'b1, 1'b0);
    cycle("stream_drain", 1'b0, 9'h000, 1'b1, 1'b0);
`ifdef CSA_RESULT_CARRY_CNT_EN
    chk("carry_sat", {24'd0, carry_cnt}, 32'hFF);
`else
    chk("carry_tied", {24'd0, carry_cnt}, 32'h00);
`endif

    for (int i = 0; i < 4; i++) cycle("pre_rst_fill", 1'b1, 9'h0C0 + 9'(i), 1'b0, 1'b0);
    cycle("pre_rst_ovf", 1'b1, 9'h0CF, 1'b1, 1'b0);
    cycle("pre_rst_lvl3", 1'b0, 9'h000, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_out_data", {23'd0, out_data}, 32'd0);
    chk("rst_carry", {24'd0, carry_cnt}, 32'd0);
    sb_q.delete(); ovf_m = 1'b0; carry_m = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("post_rst_push", 1'b1, 9'h1A5, 1'b0, 1'b0);
    cycle("post_rst_pop", 1'b0, 9'h000, 1'b1, 1'b0);
    cycle("post_rst_end", 1'b0, 9'h000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/csa_result_fifo.md
CSA_RESULT_FIFO -- requirements
Module: csa_result_fifo

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port clr  input  1  synchronous flush, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream adder result valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-006 SHALL have port in_sum  input  8  adder sum.
REQ-007 SHALL have port in_cout  input  1  adder carry-out.
REQ-008 SHALL have port out_valid  output  1  head entry available.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the head entry.
REQ-010 SHALL have port out_data  output  9  head entry, {cout, sum[7:0]}.
REQ-011 SHALL have port level  output  3  number of stored entries, 0..4.
REQ-012 SHALL have port ovf  output  1  sticky flag: a result was offered while the FIFO was full.
REQ-013 SHALL have port carry_cnt  output  8  count of accepted results with cout=1.

Function
REQ-014 SHALL store up to 4 entries of 9 bits in first-in first-out order.
REQ-015 SHALL drive in_ready = (level != 4); in_ready SHALL NOT depend on out_ready.
REQ-016 SHALL push {in_cout, in_sum} when in_valid && in_ready, with the entry visible on out_data one cycle later.
REQ-017 SHALL drive out_valid = (level != 0) and out_data = head entry combinationally from storage; out_data SHALL be 9'h000 when empty.
REQ-018 SHALL pop the head when out_valid && out_ready; the next entry appears the following cycle.
REQ-019 SHALL, on simultaneous push and pop, keep level unchanged and preserve order.
REQ-020 SHALL hold state when full and in_valid is high; no entry is overwritten.
REQ-021 SHALL set ovf on any cycle with in_valid && !in_ready; ovf stays set until clr or reset.
REQ-022 SHALL increment carry_cnt by 1 on each accepted push with in_cout=1; saturate at 8'hFF.
REQ-023 SHALL use 2-bit wrapping read/write pointers; wrap from 3 to 0 SHALL NOT corrupt data.
REQ-024 SHALL, when clr=1, empty the FIFO, clear ovf and carry_cnt next cycle; clr overrides push, pop and ovf set in that cycle.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force level=0, pointers=0, ovf=0, carry_cnt=0, out_valid=0, in_ready=1, out_data=9'h000.
REQ-026 SHALL discard all stored entries on reset asserted mid-operation; no push or pop in the cycle reset is released.
REQ-027 SHALL treat storage array contents as don't-care after reset; only pointers and level are reset.

Configuration
REQ-028 SHALL compile the carry counter only when macro CSA_RESULT_CARRY_CNT_EN is defined.
REQ-029 SHALL, with CSA_RESULT_CARRY_CNT_EN defined, implement REQ-022 and REQ-024 carry_cnt behaviour.
REQ-030 SHALL, without CSA_RESULT_CARRY_CNT_EN, tie carry_cnt to 8'h00 with no counter register; all other behaviour unchanged.

Verification
REQ-031 Reset then push sum=8'h5A cout=0, out_ready=0 -> next cycle out_valid=1, out_data=9'h05A, level=1.
REQ-032 Push 9'h101, 9'h0FF, 9'h100, 9'h00A back-to-back, out_ready=0 -> level=4, in_ready=0, then pops in that order; carry_cnt=2.
REQ-033 Full FIFO, in_valid=1 for one cycle -> ovf=1, level stays 4, contents unchanged; clr pulse -> level=0, ovf=0, carry_cnt=0.
REQ-034 Level=2, push and pop in same cycle for 6 cycles with incrementing sums -> level stays 2, output order matches input order across pointer wrap.
REQ-035 Push 260 entries with cout=1, popping continuously -> carry_cnt=8'hFF (8'h00 without CSA_RESULT_CARRY_CNT_EN).
REQ-036 Level=3, assert rst_n=0 mid-cycle -> immediately level=0, out_valid=0, in_ready=1, ovf=0.
